// File: rtl/router_fifo.sv
// router_fifo: per-port output FIFO of the 1x3 router.
// Stores DATA_W-bit bytes plus a header tag bit. The read side tracks the
// remaining bytes of the current packet in pkt_count so that data_out can
// go idle between packets.
// Optional build macro: ROUTER_FIFO_TRISTATE_EN. When it is defined,
// data_out floats to high impedance while idle. When it is undefined,
// data_out drives zero while idle.
module router_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    localparam int PKT_W = 6;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [PKT_W-1:0] PKT_ONE = {{(PKT_W-1){1'b0}}, 1'b1};

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PKT_W-1:0]  pkt_count_q, pkt_count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W:0]   rd_word;
    logic              wr_acc;
    logic              rd_acc;
`ifdef ROUTER_FIFO_TRISTATE_EN
    logic              oe_q, oe_d;
`endif

    // Flags come straight from the pointers; the MSB is the wrap bit.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                  (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
        wr_acc  = write_enb && !full;
        rd_acc  = read_enb && !empty;
        rd_word = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end

    // Next-state for pointers, packet counter and read data; flush wins.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_count_d = pkt_count_q;
        data_d      = data_q;
`ifdef ROUTER_FIFO_TRISTATE_EN
        oe_d        = oe_q;
`endif
        if (soft_reset) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pkt_count_d = '0;
            data_d      = '0;
`ifdef ROUTER_FIFO_TRISTATE_EN
            oe_d        = 1'b1;
`endif
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                data_d   = rd_word[DATA_W-1:0];
`ifdef ROUTER_FIFO_TRISTATE_EN
                oe_d     = 1'b1;
`endif
                // Header byte carries payload length in its upper six bits;
                // +1 accounts for the trailing parity byte.
                if (rd_word[DATA_W]) begin
                    pkt_count_d = rd_word[DATA_W-1 -: PKT_W] + PKT_ONE;
                end else if (pkt_count_q != '0) begin
                    pkt_count_d = pkt_count_q - PKT_ONE;
                end
            end else if (pkt_count_q == '0) begin
`ifdef ROUTER_FIFO_TRISTATE_EN
                oe_d   = 1'b0;
`else
                data_d = '0;
`endif
            end
        end
    end

    // Control and read-data registers with asynchronous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            data_q      <= '0;
`ifdef ROUTER_FIFO_TRISTATE_EN
            oe_q        <= 1'b1;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            data_q      <= data_d;
`ifdef ROUTER_FIFO_TRISTATE_EN
            oe_q        <= oe_d;
`endif
        end
    end

    // Storage array; cleared on either reset, written when not full.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (soft_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

`ifdef ROUTER_FIFO_TRISTATE_EN
    assign data_out = oe_q ? data_q : {DATA_W{1'bz}};
`else
    assign data_out = data_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Testbench for router_fifo: directed scenarios plus randomized traffic,
// checked by a queue-based reference model through a per-cycle scoreboard.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] dout;
        logic       full;
        logic       empty;
        logic [5:0] pkt;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] mq[$];
    logic [5:0] m_pkt;
    logic [7:0] m_dout;

    router_fifo #(.DEPTH(16), .DATA_W(8), .ADDR_W(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: a FIFO queue plus packet bookkeeping from the rules.
    task automatic model_step(input logic we, input logic re, input logic lfd,
                              input logic [7:0] din, input logic sr);
        logic       was_full;
        logic       was_empty;
        logic [8:0] w;
        exp_t       e;
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        if (sr) begin
            mq.delete();
            m_pkt  = 6'd0;
            m_dout = 8'h00;
        end else begin
            if (re && !was_empty) begin
                w      = mq.pop_front();
                m_dout = w[7:0];
                if (w[8]) m_pkt = w[7:2] + 6'd1;
                else if (m_pkt != 6'd0) m_pkt = m_pkt - 6'd1;
            end else if (m_pkt == 6'd0) begin
                m_dout = 8'h00;
            end
            if (we && !was_full) mq.push_back({lfd, din});
        end
        e.dout  = m_dout;
        e.full  = (mq.size() == 16);
        e.empty = (mq.size() == 0);
        e.pkt   = m_pkt;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic we, input logic re, input logic lfd,
                         input logic [7:0] din, input logic sr);
        @(negedge clock);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        soft_reset = sr;
        model_step(we, re, lfd, din, sr);
    endtask

    // Monitor: after every edge, pop the expected outputs and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data_out", {24'd0, data_out}, {24'd0, e.dout});
                chk("full", {31'd0, full}, {31'd0, e.full});
                chk("empty", {31'd0, empty}, {31'd0, e.empty});
                chk("pkt_count", {26'd0, dut.pkt_count_q}, {26'd0, e.pkt});
            end
        end
    end

    initial begin
        logic [7:0] pkt_bytes [5];
        logic [7:0] exp_rd    [5];
        logic [5:0] exp_pc    [5];
        int         wait_cnt;
        pkt_bytes = '{8'h0E, 8'hA1, 8'hA2, 8'hA3, 8'h55};
        exp_rd    = '{8'h0E, 8'hA1, 8'hA2, 8'hA3, 8'h55};
        exp_pc    = '{6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
        m_pkt      = 6'd0;
        m_dout     = 8'h00;
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;

        // 1: reset then idle
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // 2: single packet, with explicit read-sequence checks
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, (i == 0), pkt_bytes[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            @(posedge clock);
            #2;
            chk("pkt_rd", {24'd0, data_out}, {24'd0, exp_rd[i]});
            chk("pkt_cnt", {26'd0, dut.pkt_count_q}, {26'd0, exp_pc[i]});
        end
        chk("pkt_empty", {31'd0, empty}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clock);
        #2;
        chk("pkt_idle", {24'd0, data_out}, 32'd0);

        // 3: fill and overflow
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // 4: simultaneous read/write at full, then at empty
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h20 + i), 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // 5: wrap-around
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 8'(r * 16 + i), 1'b0);
            for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end

        // 6: soft reset mid-packet with a concurrent write
        cycle(1'b1, 1'b0, 1'b1, 8'h14, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'hB0 + i), 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'hEE, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Randomized traffic, alternating write-heavy and read-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 80; i++) begin
                logic we, re, lf, sr;
                we = (ph % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
                re = (ph % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
                lf = ($urandom_range(7) == 0);
                sr = ($urandom_range(63) == 0);
                cycle(we, re, lf, 8'($urandom), sr);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clock);
            wait_cnt++;
        end
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
Per-port output FIFO of the 1x3 router, directly downstream of router_sync. There is one instance per destination port, three in total.
- Accepts write_enb[i] and soft_reset_i from router_sync and stores packet bytes from the register stage.
- Returns full/empty flags that router_sync uses to produce fifo_full and vld_out_i.
- Tags each packet's header byte so the read side knows where the packet ends.

Parameters:
DEPTH, 16, number of storage entries; must be a power of 2.
DATA_W, 8, payload byte width. Each stored word is DATA_W+1 bits: bit DATA_W is the header tag.
ADDR_W, 4, log2(DEPTH).

Ports:
clock  input  1  system clock; all logic samples on the rising edge.
resetn  input  1  asynchronous active-low reset.
soft_reset  input  1  synchronous flush from router_sync after read timeout; active-high.
write_enb  input  1  write request for this FIFO.
read_enb  input  1  read request from the destination client.
lfd_state  input  1  high when the byte on data_in is the packet header; stored as the tag bit.
data_in  input  DATA_W  byte to write.
data_out  output  DATA_W  registered read data.
full  output  1  high when the FIFO holds DEPTH entries.
empty  output  1  high when the FIFO holds 0 entries.

Behaviour:
- Storage: DEPTH x (DATA_W+1) memory.
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (low address bits equal) AND (wrap bits differ).
  - Both flags are combinational from the pointers.
- Reset (resetn=0, asynchronous):
  - Pointers and pkt_count clear to 0; data_out = 0.
  - Memory contents clear to 0.
  - Outputs after reset: empty=1, full=0.
- Soft reset (soft_reset=1 at a clock edge): same clearing as reset, applied synchronously.
  - Has priority over any read or write in the same cycle.
  - Data written in that cycle is discarded.
- Write: when write_enb=1 and full=0, mem[wr_ptr] <= {lfd_state, data_in} and wr_ptr increments.
  - Writes while full are silently dropped; pointers do not change.
- Read: when read_enb=1 and empty=0, data_out <= mem[rd_ptr][DATA_W-1:0] on that edge and rd_ptr increments.
  - Read latency is 1 cycle: data is valid after the edge where the read was accepted.
  - A read while empty is ignored and data_out holds its value.
- Simultaneous read and write:
  - Each is qualified against the flags as they stood before the edge.
  - When full, only the read proceeds. When empty, only the write proceeds.
  - Otherwise both proceed and the occupancy is unchanged.
- Write-to-read latency: a byte written at edge N is readable at edge N+1, because empty deasserts after edge N.
- Packet counter pkt_count (6 bits), updated on accepted reads only:
  - If the word being read has its tag bit set: pkt_count <= data[7:2] + 1 (payload length + parity), wrapped to 6 bits.
  - Else if pkt_count != 0: pkt_count decrements.
  - pkt_count == 0 means no packet is in progress on the read side.
- data_out when idle: once pkt_count reaches 0 after the parity byte has been read, data_out is driven to 0 on the next edge with no accepted read. This holds until the next accepted read. The optional feature below changes this idle value.
- Wrap-around: both pointers wrap from DEPTH-1 to 0 and toggle their wrap bit. Full and empty must stay correct across repeated wraps.

Optional Feature:
Macro: ROUTER_FIFO_TRISTATE_EN.
- Defined: whenever pkt_count == 0 and no read is accepted, data_out is 'z (high impedance). This allows the three FIFO outputs to share a bus.
- Undefined: data_out drives 8'h00 in that condition, as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset then idle. Drive resetn=0 for 1 cycle, then 1 → empty=1, full=0, data_out=0. No change for 5 cycles with all requests low.
2. Single packet. Write header 8'h0E (length 3, addr 2) with lfd_state=1, then 8'hA1, 8'hA2, 8'hA3 and parity 8'h55 with lfd_state=0, then read 5 times → data_out sequence 0E, A1, A2, A3, 55. pkt_count sequence 4, 3, 2, 1, 0. empty=1 after the 5th read. data_out=0 (or 'z with the macro) one cycle later.
3. Fill and overflow. Write 16 bytes 8'h00..8'h0F, then a 17th write of 8'hFF → full=1 after the 16th write. The 17th write is dropped. 16 reads return 00..0F, then empty=1.
4. Simultaneous read and write. With the FIFO full, assert read_enb and write_enb with 8'h77 → only the read occurs and full drops to 0. With the FIFO empty, the same stimulus → only the write occurs and empty drops to 0.
5. Wrap-around. Repeat "write 10, read 10" three times (30 entries total) → data order is preserved, and the flags are correct on every cycle across the pointer wrap.
6. Soft reset mid-packet. Write 6 bytes, read 2, then assert soft_reset together with write_enb → empty=1, full=0, data_out=0, pkt_count=0 on the next cycle. The concurrent write is discarded.
